// File: rtl/bus_controller.sv
// bus_controller: two-master arbiter serving an on-chip byte RAM and GPIO registers, one access at a time.
// Define BUS_PRIORITY_RR_EN to replace fixed m0-first arbitration with round-robin.
module bus_controller #(
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m0_grant_request,
  input  logic       m0_rw,
  input  logic [8:0] m0_address,
  input  logic [7:0] m0_wdata,
  output logic [7:0] m0_rdata,
  output logic       m0_grant_given,
  input  logic       m1_grant_request,
  input  logic       m1_rw,
  input  logic [8:0] m1_address,
  input  logic [7:0] m1_wdata,
  output logic [7:0] m1_rdata,
  output logic       m1_grant_given,
  input  logic [7:0] gpio_in,
  output logic [7:0] gpio_out
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, GRANT} state_t;

  state_t           state;
  state_t           state_next;
  logic             winner;
  logic             lat_rw;
  logic [8:0]       lat_address;
  logic [7:0]       lat_wdata;
  logic [3:0]       count;
  logic [7:0]       gpio_meta;
  logic [7:0]       gpio_sync;
  logic [7:0]       mem [MEM_DEPTH];
  logic             pick_m1;
  logic             start;
  logic             do_access;
  logic [7:0]       read_data;
  logic [IDX_W-1:0] mem_index;

  assign mem_index = lat_address[IDX_W-1:0];

`ifdef BUS_PRIORITY_RR_EN
  // rr_prio names the master that wins the next tie: the one not granted most recently.
  logic rr_prio;

  assign pick_m1 = m1_grant_request & (~m0_grant_request | rr_prio);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_prio <= 1'b0;
    end else if (state == GRANT) begin
      rr_prio <= ~winner;
    end
  end
`else
  assign pick_m1 = m1_grant_request & ~m0_grant_request;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    do_access  = 1'b0;
    case (state)
      IDLE: begin
        if (m0_grant_request || m1_grant_request) begin
          start      = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (count == 4'd0) begin
          do_access  = 1'b1;
          state_next = GRANT;
        end
      end
      GRANT:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    read_data = 8'h00;
    if (!lat_address[8]) begin
      read_data = mem[mem_index];
    end else if (lat_address[7:0] == 8'h00) begin
      read_data = gpio_out;
    end else if (lat_address[7:0] == 8'h01) begin
      read_data = gpio_sync;
    end
  end

  // Grant rises on the edge that performs the access, so rdata and grant appear together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      winner         <= 1'b0;
      lat_rw         <= 1'b0;
      lat_address    <= 9'h000;
      lat_wdata      <= 8'h00;
      count          <= 4'd0;
      m0_grant_given <= 1'b0;
      m1_grant_given <= 1'b0;
      m0_rdata       <= 8'h00;
      m1_rdata       <= 8'h00;
      gpio_out       <= 8'h00;
      gpio_meta      <= 8'h00;
      gpio_sync      <= 8'h00;
    end else begin
      m0_grant_given <= do_access & ~winner;
      m1_grant_given <= do_access & winner;
      gpio_meta      <= gpio_in;
      gpio_sync      <= gpio_meta;
      if (start) begin
        winner      <= pick_m1;
        lat_rw      <= pick_m1 ? m1_rw      : m0_rw;
        lat_address <= pick_m1 ? m1_address : m0_address;
        lat_wdata   <= pick_m1 ? m1_wdata   : m0_wdata;
        count       <= 4'(WAIT_STATES);
      end else if (state == ACCESS && count != 4'd0) begin
        count <= count - 4'd1;
      end
      if (do_access) begin
        if (lat_rw) begin
          if (lat_address == 9'h100) begin
            gpio_out <= lat_wdata;
          end
        end else if (winner) begin
          m1_rdata <= read_data;
        end else begin
          m0_rdata <= read_data;
        end
      end
    end
  end

  // RAM is deliberately left out of reset so its contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (do_access && lat_rw && !lat_address[8]) begin
      mem[mem_index] <= lat_wdata;
    end
  end

endmodule

// File: doc/bus_controller.md
Name: bus_controller

Overview:
- Single-port bus target and arbiter that sits directly downstream of the CPU core's memory interface.
- Serves the core's byte-wide grant_request/grant_given handshake, plus a second master port used by the program loader and debug logic.
- Decodes the 9-bit address: bit 8 = 0 selects on-chip byte RAM, bit 8 = 1 selects GPIO registers.
- Exactly one access is in flight at a time.

Parameters:
- MEM_DEPTH, 256, RAM bytes; power of 2, at most 256; RAM index = address[7:0] mod MEM_DEPTH.
- WAIT_STATES, 1, extra ACCESS cycles before each access completes; range 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- m0_grant_request  in  1  core requests an access; held until grant seen.
- m0_rw  in  1  1 = write, 0 = read.
- m0_address  in  9  bit 8 = GPIO flag, bits 7:0 = byte address.
- m0_wdata  in  8  write data (core data_out).
- m0_rdata  out  8  read data (core data_in); holds last read value for m0.
- m0_grant_given  out  1  one-cycle completion pulse to core.
- m1_grant_request, m1_rw, m1_address, m1_wdata, m1_rdata, m1_grant_given: same widths and meanings as m0_*, for the loader port.
- gpio_in  in  8  external input pins (asynchronous).
- gpio_out  out  8  output register.

Behaviour:
- Reset (reset = 0, asynchronous): state = IDLE; m0/m1_grant_given = 0; m0/m1_rdata = 0; gpio_out = 0; wait counter = 0; rr pointer = m0. RAM contents are not cleared.
- Reset asserted mid-access: access is aborted and no RAM/GPIO write occurs unless the write edge has already passed.
- IDLE:
  - At a clock edge with any request high, select the winner (default fixed priority: m0 over m1).
  - Latch winner id, rw, address and wdata into internal registers; load counter = WAIT_STATES; go to ACCESS.
  - No requests: stay in IDLE.
- ACCESS:
  - counter != 0: decrement.
  - counter == 0: perform the access from the latched values and go to GRANT.
  - Later changes on master inputs are ignored. A request withdrawn mid-access still completes and still pulses grant.
- GRANT: winner's grant_given = 1 for exactly one cycle; winner's rdata is valid in the same cycle; next state is IDLE unconditionally.
- Latency: request sampled at edge N → grant_given high in the cycle after edge N+1+WAIT_STATES. Throughput is one access per WAIT_STATES+3 cycles.
- Re-service guard: GRANT→IDLE costs one cycle, so a master that drops its request on the edge where it sees grant is never served twice.
- Masters must hold request, rw, address and wdata stable until grant; holding beyond that is legal only if a new access is intended.
- RAM (address[8] = 0):
  - Write stores wdata.
  - Read loads the winner's rdata with mem[index].
- GPIO (address[8] = 1):
  - Offset 0x00: gpio_out, read/write.
  - Offset 0x01: gpio_in after a 2-flop synchroniser, read-only; writes ignored.
  - Other offsets: reads return 0x00, writes ignored.
- rdata registers: a write access leaves the winner's rdata unchanged. The non-winner's rdata and grant_given are never touched.

Optional Feature:
- Macro: BUS_PRIORITY_RR_EN.
- Defined: round-robin arbitration. On simultaneous requests in IDLE, the master not granted most recently wins; rr pointer updates at every GRANT.
- Undefined: fixed priority, m0 always wins ties; rr pointer logic is absent.
- Single-requester behaviour and latency are identical in both builds.

Test Plan:
- Reset, then m0 write 0xA5 to 0x010, then m0 read 0x010 (WAIT_STATES = 1) → each grant is a single-cycle pulse 3 cycles after the request edge; read returns m0_rdata = 0xA5.
- m0 write 0x3C to address 0x100, then read 0x100 → gpio_out = 0x3C after the write grant; read returns 0x3C. m0 write to 0x101 → gpio_out unchanged.
- gpio_in = 0x5A, wait 2 cycles, m0 read 0x101 → 0x5A. m0 read 0x1FF → 0x00.
- m0 and m1 raise requests on the same edge, repeated 3 times:
  - Fixed-priority build: m0 is granted first every time.
  - BUS_PRIORITY_RR_EN build: grants alternate m0, m1, m0.
  - In both builds, m1_rdata is untouched during m0 accesses.
- m0 write 0x77 to 0x020, with reset pulsed low during ACCESS (WAIT_STATES = 3) → no grant; all outputs 0 immediately; a subsequent read of 0x020 returns the prior contents, not 0x77.
- m0 holds its request for exactly the cycle it sees grant, then drops it → exactly one access is performed; state returns to IDLE; no second grant.
